instr_encoder_loader: RTL and testbench

- Inverse of the core's instruction decoder: accepts instruction fields (operation select, rd, rs1, rs2, imm) over a valid/ready handshake.
- Encodes each into a 32-bit RV32I word using the exact opcode/funct3/funct7 set the control unit decodes.
- Writes the words sequentially into instruction memory.
- Programs instruction memory from a host/bench without a hex file. Sits between the program source and the instruction-memory write port.

---
 rtl/instr_encoder_loader.sv | 156 +++++++++++++++
 tb/tb_instr_encoder_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes RV32I field bundles and streams them into instruction memory
// One bundle per handshake: capture, encode (ENC), write (WR); addresses advance only on legal writes.
module instr_encoder_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [12:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR, S_FULL} state_t;

  state_t              state_q, state_d;
  logic                live_q;
  logic [4:0]          op_q, rd_q, rs1_q, rs2_q;
  logic [12:0]         imm_q;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic [31:0]         enc;
  logic                legal;
  logic                accept;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, rs2_q, rs1_q, f3, rd_q, OP_R};
  endfunction

  function automatic logic [31:0] i_type(input logic [2:0] f3, input logic [6:0] opc);
    return {imm_q[11:0], rs1_q, f3, rd_q, opc};
  endfunction

  always_comb begin
    enc   = 32'h0;
    legal = 1'b1;
    case (op_q)
      5'd0:  enc = r_type(7'b0000000, 3'b000);
      5'd1:  enc = r_type(7'b0100000, 3'b000);
      5'd2:  enc = r_type(7'b0000000, 3'b111);
      5'd3:  enc = r_type(7'b0000000, 3'b110);
      5'd4:  enc = r_type(7'b0000000, 3'b010);
      5'd5:  enc = i_type(3'b000, OP_I);
      5'd6:  enc = i_type(3'b000, OP_L);
      5'd7:  enc = {imm_q[11:5], rs2_q, rs1_q, 3'b000, imm_q[4:0], OP_S};
      5'd8:  enc = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000, imm_q[4:1], imm_q[11], OP_B};
      5'd9:  enc = i_type(3'b111, OP_I);
      5'd10: enc = i_type(3'b110, OP_I);
      5'd11: enc = r_type(7'b0000000, 3'b100);
      5'd12: enc = i_type(3'b100, OP_I);
      5'd13: enc = r_type(7'b0000000, 3'b001);
      5'd14: enc = {7'b0, imm_q[4:0], rs1_q, 3'b001, rd_q, OP_I};
      5'd15: enc = r_type(7'b0000000, 3'b101);
      5'd16: enc = {7'b0, imm_q[4:0], rs1_q, 3'b101, rd_q, OP_I};
      default: legal = 1'b0;
    endcase
  end

  // clear blocks acceptance in its own cycle so a restart never swallows a bundle
  assign full      = (count_q == DEPTH_C);
  assign in_ready  = live_q && (state_q == S_IDLE) && !full && !clear;
  assign accept    = in_valid && in_ready;
  assign mem_we    = (state_q == S_WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    if (clear) begin
      state_d = S_IDLE;
      addr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) state_d = S_ENC;
        S_ENC: begin
          if (legal) begin
            wdata_d = enc;
            state_d = S_WR;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_WR: begin
          count_d = count_q + (ADDR_W+1)'(1);
          // the last word's address is held rather than wrapping past the region
          if (count_d == DEPTH_C) state_d = S_FULL;
          else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_IDLE;
          end
        end
        default: state_d = S_FULL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (accept) begin
        op_q  <= op_sel;
        rd_q  <= rd;
        rs1_q <= rs1;
        rs2_q <= rs2;
        imm_q <= imm;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed bench for instr_encoder_loader (DEPTH=4 to reach full quickly)
module tb_instr_encoder_loader;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        op_sel = '0, rd = '0, rs1 = '0, rs2 = '0;
  logic [12:0]       imm = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // presents one bundle (DUT assumed idle/ready), returns at the negedge of the ENC cycle
  task automatic drive_bundle(input logic [4:0] o, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [12:0] im);
    op_sel = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({in_ready, mem_we, full, err} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {in_ready, mem_we, full, err}); end
    n_cmp++; if (mem_addr !== '0 || count !== '0) begin n_bad++; $display("FAIL reset_addr_count: got %0d/%0d want 0/0", mem_addr, count); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 00000000", mem_wdata); end
    reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_pre_edge: got %0b want 0", in_ready); end
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_post_edge: got %0b want 1", in_ready); end
  endtask

  task automatic test_add();
    drive_bundle(5'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    n_cmp++; if (mem_we !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL add_enc: got we=%0b rdy=%0b want 0 0", mem_we, in_ready); end
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL add_we: got %0b want 1", mem_we); end
    n_cmp++; if (mem_addr !== 2'd0) begin n_bad++; $display("FAIL add_addr: got %0d want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h002081B3) begin n_bad++; $display("FAIL add_wdata: got %h want 002081b3", mem_wdata); end
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0 || count !== 3'd1 || mem_addr !== 2'd1) begin n_bad++; $display("FAIL add_after: got we=%0b cnt=%0d addr=%0d want 0 1 1", mem_we, count, mem_addr); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready_back: got %0b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ops [3] = '{5'd1, 5'd5, 5'd7};
    logic [4:0]  rds [3] = '{5'd5, 5'd1, 5'd0};
    logic [4:0]  s1s [3] = '{5'd6, 5'd0, 5'd1};
    logic [4:0]  s2s [3] = '{5'd7, 5'd0, 5'd2};
    logic [12:0] ims [3] = '{13'd0, 13'h1FFF, 13'd4};
    logic [31:0] exp [3] = '{32'h407302B3, 32'hFFF00093, 32'h00208223};
    do_clear();
    op_sel = ops[0]; rd = rds[0]; rs1 = s1s[0]; rs2 = s2s[0]; imm = ims[0];
    in_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== (i % 3 == 0)) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %0b want %0b", i, in_ready, (i % 3 == 0)); end
      n_cmp++; if (mem_we !== (i % 3 == 2)) begin n_bad++; $display("FAIL b2b_we[%0d]: got %0b want %0b", i, mem_we, (i % 3 == 2)); end
      if (i % 3 == 2) begin
        n_cmp++; if (mem_addr !== ADDR_W'(i / 3)) begin n_bad++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", i, mem_addr, i / 3); end
        n_cmp++; if (mem_wdata !== exp[i/3]) begin n_bad++; $display("FAIL b2b_wdata[%0d]: got %h want %h", i, mem_wdata, exp[i/3]); end
        if (i / 3 < 2) begin
          op_sel = ops[i/3+1]; rd = rds[i/3+1]; rs1 = s1s[i/3+1]; rs2 = s2s[i/3+1]; imm = ims[i/3+1];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    n_cmp++; if (count !== 3'd3 || full !== 1'b0) begin n_bad++; $display("FAIL b2b_count: got cnt=%0d full=%0b want 3 0", count, full); end
  endtask

  task automatic test_encodings();
    logic [4:0]  ops [7] = '{5'd8, 5'd14, 5'd2, 5'd12, 5'd15, 5'd6, 5'd8};
    logic [4:0]  rds [7] = '{5'd0, 5'd1, 5'd4, 5'd2, 5'd1, 5'd7, 5'd31};
    logic [4:0]  s1s [7] = '{5'd1, 5'd1, 5'd5, 5'd3, 5'd2, 5'd8, 5'd1};
    logic [4:0]  s2s [7] = '{5'd2, 5'd0, 5'd6, 5'd0, 5'd3, 5'd0, 5'd2};
    logic [12:0] ims [7] = '{13'd8, 13'h07E3, 13'd0, 13'h00F0, 13'd0, 13'h1FFC, 13'h1FF9};
    logic [31:0] exp [7] = '{32'h00208463, 32'h00309093, 32'h0062F233, 32'h0F01C113,
                             32'h003150B3, 32'hFFC40383, 32'hFE208CE3};
    for (int i = 0; i < 7; i++) begin
      do_clear();
      drive_bundle(ops[i], rds[i], s1s[i], s2s[i], ims[i]);
      @(negedge clk);
      n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 2'd0) begin n_bad++; $display("FAIL enc_we[%0d]: got we=%0b addr=%0d want 1 0", i, mem_we, mem_addr); end
      n_cmp++; if (mem_wdata !== exp[i]) begin n_bad++; $display("FAIL enc_wdata[%0d]: got %h want %h", i, mem_wdata, exp[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    do_clear();
    drive_bundle(5'd20, 5'd3, 5'd1, 5'd2, 13'd0);
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL ill_we_enc: got %0b want 0", mem_we); end
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL ill_we: got %0b want 0", mem_we); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ill_err: got %0b want 1", err); end
    n_cmp++; if (count !== 3'd0 || mem_addr !== 2'd0) begin n_bad++; $display("FAIL ill_count: got cnt=%0d addr=%0d want 0 0", count, mem_addr); end
    n_cmp++; if (mem_wdata !== 32'hFE208CE3) begin n_bad++; $display("FAIL ill_wdata_held: got %h want fe208ce3", mem_wdata); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ill_ready: got %0b want 1", in_ready); end
    drive_bundle(5'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'h002081B3) begin n_bad++; $display("FAIL ill_next_write: got we=%0b addr=%0d data=%h want 1 0 002081b3", mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    n_cmp++; if (count !== 3'd1 || err !== 1'b1) begin n_bad++; $display("FAIL ill_sticky: got cnt=%0d err=%0b want 1 1", count, err); end
    do_clear();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ill_err_clear: got %0b want 0", err); end
  endtask

  task automatic test_full();
    logic [31:0] want;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      drive_bundle(5'd0, 5'(i + 1), 5'd1, 5'd2, 13'd0);
      @(negedge clk);
      want = 32'h00208033 | (32'(i + 1) << 7);
      n_cmp++; if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(i) || mem_wdata !== want) begin n_bad++; $display("FAIL full_fill[%0d]: got we=%0b addr=%0d data=%h want 1 %0d %h", i, mem_we, mem_addr, mem_wdata, i, want); end
      @(negedge clk);
    end
    n_cmp++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin n_bad++; $display("FAIL full_state: got full=%0b rdy=%0b cnt=%0d want 1 0 4", full, in_ready, count); end
    n_cmp++; if (mem_addr !== 2'd3) begin n_bad++; $display("FAIL full_addr_hold: got %0d want 3", mem_addr); end
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++; if (mem_we !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ignore[%0d]: got we=%0b rdy=%0b want 0 0", i, mem_we, in_ready); end
    end
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_count_hold: got %0d want 4", count); end
    do_clear();
    #1;
    n_cmp++; if (count !== 3'd0 || full !== 1'b0 || in_ready !== 1'b1 || mem_addr !== 2'd0) begin n_bad++; $display("FAIL full_clear: got cnt=%0d full=%0b rdy=%0b addr=%0d want 0 0 1 0", count, full, in_ready, mem_addr); end
    drive_bundle(5'd1, 5'd5, 5'd6, 5'd7, 13'd0);
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'h407302B3) begin n_bad++; $display("FAIL full_rewrite: got we=%0b addr=%0d data=%h want 1 0 407302b3", mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    do_clear();
    drive_bundle(5'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0 || count !== '0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin n_bad++; $display("FAIL abort_reset: got we=%0b cnt=%0d addr=%0d data=%h want 0 0 0 0", mem_we, count, mem_addr, mem_wdata); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || mem_we !== 1'b0 || count !== '0) begin n_bad++; $display("FAIL abort_reset_after: got rdy=%0b we=%0b cnt=%0d want 1 0 0", in_ready, mem_we, count); end
    drive_bundle(5'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    @(negedge clk);
    @(negedge clk);
    drive_bundle(5'd1, 5'd5, 5'd6, 5'd7, 13'd0);
    clear = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0 || count !== '0 || mem_addr !== '0) begin n_bad++; $display("FAIL abort_clear: got we=%0b cnt=%0d addr=%0d want 0 0 0", mem_we, count, mem_addr); end
    clear = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_clear_ready: got %0b want 1", in_ready); end
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0 || mem_wdata !== 32'h002081B3) begin n_bad++; $display("FAIL abort_clear_dropped: got we=%0b data=%h want 0 002081b3", mem_we, mem_wdata); end
    op_sel = 5'd0; rd = 5'd9; rs1 = 5'd1; rs2 = 5'd2; imm = '0;
    in_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (mem_we !== 1'b0 || count !== '0) begin n_bad++; $display("FAIL clear_valid_same[%0d]: got we=%0b cnt=%0d want 0 0", i, mem_we, count); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_encodings();
    test_illegal();
    test_full();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
